// File: rtl/grid_display_arbiter.sv
// grid_display_arbiter: 32x24 snake-game cell RAM shared between the VGA pixel
// fetch (always wins) and the game read/write port, with a one-entry display
// cache, a fixed 2-cycle coordinate-to-colour pipeline and a clear sequencer.
module grid_display_arbiter #(
   parameter int          H_CELLS = 32,
   parameter int          V_CELLS = 24,
   parameter int          CELL_PX = 20,
   parameter logic [11:0] C_BG    = 12'h000,
   parameter logic [11:0] C_BODY  = 12'h0F0,
   parameter logic [11:0] C_HEAD  = 12'h00F,
   parameter logic [11:0] C_FOOD  = 12'hF00
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic [9:0]  data_h,
   input  logic [9:0]  data_v,
   output logic [11:0] data,
   input  logic        clr,
   output logic        busy,
   input  logic        req,
   input  logic        we,
   input  logic [9:0]  addr,
   input  logic [1:0]  wdata,
   output logic        gnt,
   output logic [1:0]  rdata,
   output logic        rvalid
);

   localparam int         N       = H_CELLS * V_CELLS;
   localparam logic [9:0] LP_N    = 10'(N);
   localparam logic [9:0] LP_LAST = 10'(N - 1);
   localparam logic [9:0] LP_PX   = 10'(CELL_PX);
   localparam logic [9:0] LP_H    = 10'(H_CELLS);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_clr_cnt, w_clr_cnt_nxt;
   logic [9:0]  w_daddr;
   logic        w_hit, w_miss;
   logic [9:0]  r_p1_addr;
   logic        r_p1_miss, r_p1_valid;
   logic [9:0]  r_cache_addr;
   logic [1:0]  r_cache_val;
   logic        r_cache_ok;
   logic [1:0]  r_mem [N];
   logic [1:0]  r_ram_q;
   logic [9:0]  w_ram_addr;
   logic        w_ram_we;
   logic [1:0]  w_ram_wd;
   logic        w_addr_ok, w_game_wr, w_game_rd;
   logic        r_rvalid, r_rd_oob;
   logic [11:0] r_data, w_colour;
   logic [1:0]  w_cell;

   assign w_daddr   = (data_v / LP_PX) * LP_H + (data_h / LP_PX);
   assign w_addr_ok = (addr < LP_N);
   // While a fill is in flight only its own address may hit: the cache entry
   // is about to be replaced, so an older cached address would read wrong data.
   assign w_hit     = (r_cache_ok && !r_p1_miss && (w_daddr == r_cache_addr)) ||
                      (r_p1_miss && (w_daddr == r_p1_addr));
   assign w_game_wr = req & gnt & we & w_addr_ok;
   assign w_game_rd = req & gnt & ~we;

   // State register and clear counter
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   // Next state, RAM port arbitration and grant
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      busy          = 1'b0;
      gnt           = 1'b0;
      w_miss        = 1'b0;
      w_ram_addr    = w_daddr;
      w_ram_we      = 1'b0;
      w_ram_wd      = '0;
      case (r_state)
         S_CLEAR: begin
            busy       = 1'b1;
            w_ram_addr = r_clr_cnt;
            w_ram_we   = 1'b1;
            if (clr) begin
               w_clr_cnt_nxt = '0;
            end else if (r_clr_cnt == LP_LAST) begin
               w_state_nxt   = S_RUN;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 10'd1;
            end
         end
         S_RUN: begin
            w_miss = !w_hit;
            gnt    = w_hit;
            if (w_hit) begin
               w_ram_addr = w_addr_ok ? addr : '0;
               w_ram_we   = req & we & w_addr_ok;
               w_ram_wd   = wdata;
            end
            if (clr) begin
               w_state_nxt   = S_CLEAR;
               w_clr_cnt_nxt = '0;
            end
         end
      endcase
   end

   // Single-port cell RAM with registered read
   always_ff @(posedge clk25) begin
      if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wd;
      r_ram_q <= r_mem[w_ram_addr];
   end

   // Display cache: fill on a completed miss, write-through on game writes
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_cache_ok   <= 1'b0;
         r_cache_addr <= '0;
         r_cache_val  <= '0;
      end else if (w_state_nxt == S_CLEAR) begin
         r_cache_ok <= 1'b0;
      end else if (r_p1_miss) begin
         r_cache_ok   <= 1'b1;
         r_cache_addr <= r_p1_addr;
         r_cache_val  <= (w_game_wr && (addr == r_p1_addr)) ? wdata : r_ram_q;
      end else if (w_game_wr && (addr == r_cache_addr)) begin
         r_cache_val <= wdata;
      end
   end

   // Stage-1 cell selection and colour lookup
   always_comb begin
      w_cell = r_p1_miss ? r_ram_q : r_cache_val;
      case (w_cell)
         2'd0:    w_colour = C_BG;
         2'd1:    w_colour = C_BODY;
         2'd2:    w_colour = C_HEAD;
         default: w_colour = C_FOOD;
      endcase
   end

   // Pixel pipeline and game read-valid registers
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_p1_valid <= 1'b0;
         r_p1_miss  <= 1'b0;
         r_p1_addr  <= '0;
         r_data     <= '0;
         r_rvalid   <= 1'b0;
         r_rd_oob   <= 1'b0;
      end else begin
         r_p1_valid <= (r_state == S_RUN);
         r_p1_miss  <= w_miss;
         r_p1_addr  <= w_daddr;
         r_data     <= (r_p1_valid && (w_state_nxt == S_RUN)) ? w_colour : '0;
         r_rvalid   <= w_game_rd;
         r_rd_oob   <= !w_addr_ok;
      end
   end

   assign data   = r_data;
   assign rvalid = r_rvalid;
   assign rdata  = (r_rvalid && !r_rd_oob) ? r_ram_q : '0;

endmodule

// File: tb/tb_grid_display_arbiter.sv
// Directed self-checking bench for grid_display_arbiter.
module tb_grid_display_arbiter;

   logic        clk25 = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  data_h = '0;
   logic [9:0]  data_v = '0;
   logic [11:0] data;
   logic        clr = 1'b0;
   logic        busy;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [9:0]  addr = '0;
   logic [1:0]  wdata = '0;
   logic        gnt;
   logic [1:0]  rdata;
   logic        rvalid;

   int n_checks = 0;
   int n_errors = 0;

   grid_display_arbiter #(
      .H_CELLS(32), .V_CELLS(24), .CELL_PX(20),
      .C_BG(12'h000), .C_BODY(12'h0F0), .C_HEAD(12'h00F), .C_FOOD(12'hF00)
   ) dut (
      .clk25(clk25), .rst_n(rst_n), .data_h(data_h), .data_v(data_v),
      .data(data), .clr(clr), .busy(busy), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid)
   );

   always #20 clk25 = ~clk25;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk25);
      #1;
   endtask

   // Called and returns at posedge+1; holds the request until granted.
   task automatic game_op(input logic w, input logic [9:0] a, input logic [1:0] d,
                          output logic [1:0] rd, output logic vld);
      int unsigned n = 0;
      req = 1'b1; we = w; addr = a; wdata = d; rd = '0; vld = 1'b0;
      #1;
      while (!gnt && n < 100) begin
         step();
         #1;
         n++;
      end
      if (!gnt) begin
         check("gnt_timeout", 32'(gnt), 32'd1);
         req = 1'b0;
         step();
      end else begin
         @(posedge clk25);
         #1;
         req = 1'b0; we = 1'b0;
         vld = rvalid;
         rd  = rdata;
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [1:0] d);
      logic [1:0] rd;
      logic       vld;
      game_op(1'b1, a, d, rd, vld);
   endtask

   task automatic rd_chk(input string tag, input logic [9:0] a, input logic [1:0] exp);
      logic [1:0] rd;
      logic       vld;
      game_op(1'b0, a, 2'd0, rd, vld);
      check({tag, "_rvalid"}, 32'(vld), 32'd1);
      check(tag, 32'(rd), 32'(exp));
   endtask

   // Counts cycles with busy high; data and gnt must stay 0 throughout.
   task automatic clear_len(input string tag);
      int n = 0;
      int bad = 0;
      while (busy && n < 2000) begin
         if (data !== 12'h000 || gnt !== 1'b0) bad++;
         step();
         n++;
      end
      check(tag, 32'(n), 32'd768);
      check({tag, "_quiet"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [9:0]  th [3];
      logic [9:0]  tv [3];
      logic [11:0] tex [3];
      int k;

      // Reset state
      repeat (3) step();
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_data", 32'(data), 32'h000);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      rst_n = 1'b1;
      clear_len("boot_clear");
      rd_chk("rd0", 10'd0, 2'd0);
      rd_chk("rd383", 10'd383, 2'd0);
      rd_chk("rd767", 10'd767, 2'd0);

      // Pixel pipeline: pending-fill hit, then neighbour-cell miss
      wr(10'd33, 2'd2);
      th  = '{10'd25, 10'd25, 10'd19};
      tv  = '{10'd25, 10'd25, 10'd25};
      tex = '{12'h00F, 12'h00F, 12'h000};
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            data_h = th[i]; data_v = tv[i];
         end else begin
            data_h = '0; data_v = '0;
         end
         if (i >= 2) check($sformatf("pix%0d", i - 2), 32'(data), 32'(tex[i - 2]));
         step();
      end

      // Row-0 sweep with continuous game writes
      data_h = 10'd25; data_v = 10'd25;
      repeat (3) step();
      k = 0;
      for (int h = 0; h < 640; h++) begin
         data_h = 10'(h); data_v = '0;
         req = 1'b1; we = 1'b1; addr = 10'(64 + k); wdata = 2'(k);
         #1;
         check($sformatf("sweep_gnt_h%0d", h), 32'(gnt), 32'((h % 20) != 0));
         if (gnt) k++;
         @(posedge clk25);
         #1;
      end
      req = 1'b0; we = 1'b0; data_h = '0; data_v = '0;
      check("sweep_grants", 32'(k), 32'd608);
      for (int j = 0; j < 608; j += 19)
         rd_chk($sformatf("sweep_rd%0d", 64 + j), 10'(64 + j), 2'(j % 4));

      // Write-through on the displayed cell, and out-of-range access
      data_h = 10'd25; data_v = 10'd25;
      repeat (3) step();
      check("hold_head", 32'(data), 32'h00F);
      wr(10'd33, 2'd3);
      step();
      check("wt_food", 32'(data), 32'hF00);
      wr(10'd800, 2'd1);
      rd_chk("oob_rd", 10'd800, 2'd0);
      rd_chk("oob_alias", 10'd32, 2'd0);

      // Fill every cell, then clear on request
      data_h = '0; data_v = '0;
      for (int a = 0; a < 768; a++) wr(10'(a), 2'd1);
      repeat (2) step();
      check("fill_body", 32'(data), 32'h0F0);
      clr = 1'b1;
      step();
      clr = 1'b0; req = 1'b1; we = 1'b0; addr = 10'd5;
      check("clr_busy", 32'(busy), 32'd1);
      clear_len("clr_clear");
      req = 1'b0;
      step();
      rd_chk("clr_rd0", 10'd0, 2'd0);
      rd_chk("clr_rd5", 10'd5, 2'd0);
      rd_chk("clr_rd400", 10'd400, 2'd0);
      rd_chk("clr_rd767", 10'd767, 2'd0);

      // Reset in the middle of a clear
      wr(10'd767, 2'd3);
      clr = 1'b1;
      step();
      clr = 1'b0;
      repeat (400) step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd1);
      check("mid_rst_data", 32'(data), 32'h000);
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      step();
      rst_n = 1'b1;
      clear_len("mid_rst_clear");
      rd_chk("mid_rst_rd767", 10'd767, 2'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/grid_display_arbiter.md
# grid_display_arbiter

Owns the snake game's cell memory: a 32×24 grid of 2-bit cell codes, one per 20×20-pixel tile of the 640×480 screen. It shares a single-port synchronous RAM between two users: the VGA driver's pixel fetch and the game logic's read/write port. Display fetches always win, and the game port gets every cycle the display does not need. The block turns the driver's `data_h`/`data_v` into the 12-bit `data` colour with a fixed 2-cycle latency. It also runs a clear sequencer after reset and on request.

## Interface
- `H_CELLS`, 32, grid columns
- `V_CELLS`, 24, grid rows; cell count N = H_CELLS*V_CELLS = 768
- `CELL_PX`, 20, tile edge in pixels
- `C_BG`, 12'h000, colour for code 0 (empty)
- `C_BODY`, 12'h0F0, colour for code 1
- `C_HEAD`, 12'h00F, colour for code 2
- `C_FOOD`, 12'hF00, colour for code 3

- `clk25`  in  1  pixel clock; all logic is on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `data_h`  in  10  pixel column from the VGA driver (0 during blanking)
- `data_v`  in  10  pixel row from the VGA driver (0 during blanking)
- `data`  out  12  pixel colour to the VGA driver
- `clr`  in  1  single-cycle pulse that starts a grid clear
- `busy`  out  1  high while a clear is in progress
- `req`  in  1  game-port request
- `we`  in  1  1 = write, 0 = read; qualified by `req`
- `addr`  in  10  cell address, row*H_CELLS + col
- `wdata`  in  2  cell code to write
- `gnt`  out  1  combinational grant; a transfer occurs on the cycle where `req & gnt`
- `rdata`  out  2  read result
- `rvalid`  out  1  one-cycle pulse when `rdata` is valid

## Operation
- Display address: `daddr = (data_v/CELL_PX)*H_CELLS + data_h/CELL_PX`, using constant combinational division.
- Cache: holds one register pair, `cache_addr` plus `cache_val`, and a `cache_ok` flag.
  - Hit: `cache_ok && daddr == cache_addr`.
  - Miss: everything else.
- States: CLEAR and RUN.
  - Reset enters CLEAR with `clr_cnt` = 0.
  - CLEAR writes code 0 to `clr_cnt` every cycle and increments it. After writing N-1 it moves to RUN.
  - In CLEAR: `busy` = 1, `gnt` = 0, `cache_ok` = 0, and the pipeline forces `data` to 12'h000.
  - `clr` in RUN moves to CLEAR on the next edge with `clr_cnt` = 0.
  - `clr` in CLEAR restarts the count at 0.
- RAM port arbitration in RUN, in priority order:
  1. Display miss: read `daddr`, `gnt` = 0.
  2. Otherwise `gnt` = 1 and the game request (if any) uses the port.
- Game write at `addr` < N: RAM is written. If `addr == cache_addr`, `cache_val` is also updated on the same edge (write-through).
- Game write at `addr` ≥ N: granted and discarded.
- Game read: `rdata` = RAM[`addr`] with `rvalid` high on the following cycle. If `addr` ≥ N, `rdata` = 0.
- Colour map: code 0→`C_BG`, 1→`C_BODY`, 2→`C_HEAD`, 3→`C_FOOD`.

## Timing
- Pixel pipeline:
  - Cycle t: `daddr` is formed; on a miss the RAM read is issued.
  - Cycle t+1: the cell value is `cache_val` on a hit, or the RAM output on a miss. On a miss, `cache_addr`/`cache_val`/`cache_ok` are loaded at the end of t+1.
  - Cycle t+2: `data` is registered with the colour of the coordinate presented at t, whether hit or miss.
- Hit/miss for back-to-back coordinates: the hit test at t+1 also matches against the address captured at t (pending fill). The second of two consecutive same-cell coordinates is therefore a hit.
- Display bandwidth: at most 1 miss per CELL_PX cycles during active video, plus 1 per line start. The game port is granted at least 19 of every 20 active cycles and every blanking cycle after the first.
- Clear takes exactly N = 768 cycles. `busy` falls on the first RUN cycle; `gnt` may be 1 in that same cycle.
- Simultaneous events:
  - Display miss and game `req` in the same cycle: display wins, `gnt` = 0. The requester holds `req` and its fields until granted.
  - Game write to the cell currently displayed: the new colour appears at `data` for a coordinate presented at t+1 or later.
  - `clr` and `req` in the same RUN cycle: that request is granted normally; CLEAR takes effect on the next edge.
- Reset values, asynchronous on `rst_n` low:
  - state = CLEAR, `clr_cnt` = 0
  - `busy` = 1
  - `data` = 0, `rdata` = 0, `rvalid` = 0
  - `cache_ok` = 0, pipeline valid bits = 0
  - `gnt` = 0 (derived from state)
- Reset asserted mid-clear or mid-read: the clear restarts from 0 and any pending `rvalid` is dropped. RAM contents are not reset but are overwritten by the clear.

## Test plan
- Release reset: `busy` = 1 for exactly 768 cycles and `data` = 0 throughout. Afterwards, reads of addresses 0, 383 and 767 return `rdata` = 0 with `rvalid` one cycle later.
- Write `addr` 33 with `wdata` 2, then present (25,25), (25,25), (19,25): `data` = 12'h00F, 12'h00F, 12'h000, each exactly 2 cycles after its coordinate.
- Sweep `data_h` 0→639 on row 0 with `req` held high: `gnt` = 0 exactly on the 32 miss cycles (h = 0, 20, …, 620) and 1 elsewhere; every `req & gnt` write lands.
- Hold the display on cell 33 (hit) and write `wdata` 3 to 33: `data` becomes 12'hF00 by 2 cycles after the grant. Write 1 to `addr` 800: no RAM change, and a read of 800 returns 0.
- Pulse `clr` in RUN after filling cells with 1: `busy` rises next cycle, `gnt` = 0 and `data` = 0 for 768 cycles, then all cells read 0.
- Assert `rst_n` low at `clr_cnt` = 400, release it: `busy` stays high for a full 768 cycles, with `rvalid` and `data` = 0 during reset.
